mesh_switch_allocator: RTL and testbench
========================================

MESH_SWITCH_ALLOCATOR -- requirements
Module: mesh_switch_allocator

Interface
REQ-001 SHALL have parameter N_PORTS, default 5, the number of router ports in [c,n,e,s,w] order, index 0 = c.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port i_output_req, input, [0:N_PORTS-1][0:N_PORTS-1]; per input port, the one-hot output request from that port's route calculator; all-zero means no request.
REQ-005 SHALL have port i_tail, input, [0:N_PORTS-1]; the head-of-queue flit at that input is a tail flit, meaningful only while that input requests.
REQ-006 SHALL have port i_en, input, [0:N_PORTS-1]; the output port can accept a flit this cycle (downstream ready/credit).
REQ-007 SHALL have port o_output_grant, output, [0:N_PORTS-1][0:N_PORTS-1]; per output, a one-hot select of the winning input for the crossbar.
REQ-008 SHALL have port o_input_grant, output, [0:N_PORTS-1]; the input's flit is transferred this cycle and shall be dequeued.

Function
REQ-009 SHALL give each output an independent 2-state FSM, IDLE or LOCKED(owner), plus a round-robin priority pointer.
REQ-010 SHALL compute grants combinationally in the same cycle as the request, with zero-cycle request-to-grant latency; FSM and pointer update at the next edge.
REQ-011 In IDLE with i_en high, SHALL grant the first requesting input at or after the pointer, searching cyclically with wrap from N_PORTS-1 to 0.
REQ-012 In LOCKED, SHALL grant only the owner, and only while the owner requests this output and i_en is high; other inputs are never granted.
REQ-013 With i_en low, SHALL assert no grant on that output and leave the FSM and pointer unchanged.
REQ-014 A transfer is a grant in a given cycle; o_input_grant[i] SHALL be the OR of column i over all o_output_grant.
REQ-015 On an IDLE transfer with i_tail low, SHALL go to LOCKED(winner).
REQ-016 On a transfer with i_tail high (single-flit packet or tail), SHALL go to or stay in IDLE.
REQ-017 On every tail transfer, SHALL set the pointer to (granted input + 1) mod N_PORTS.
REQ-018 If the owner drops its request while LOCKED (bubble), SHALL stay LOCKED with no grant.
REQ-019 Each output SHALL be granted to at most one input per cycle.
REQ-020 Each input SHALL be granted at most one output per cycle; one-hot inputs make this structural.
REQ-021 A multi-hot i_output_req row is illegal; the bench SHALL flag it with an assertion, and RTL behaviour is then unspecified.

Reset
REQ-022 While reset is high at an edge, SHALL set every FSM to IDLE and every pointer to 0 (input c highest priority).
REQ-023 While reset is high, o_output_grant and o_input_grant SHALL be all-zero.
REQ-024 Reset mid-packet SHALL drop all locks; packet recovery upstream is out of scope.

Configuration
REQ-025 Macro SWITCH_ALLOC_LOCK_EN, when defined, SHALL enable wormhole locking per REQ-015 to REQ-018.
REQ-026 When SWITCH_ALLOC_LOCK_EN is undefined:
- every output SHALL stay IDLE and arbitrate per flit;
- i_tail SHALL be ignored;
- the pointer SHALL advance to (granted input + 1) on every transfer.

Structure
REQ-027 Shared package MESH_pkg SHALL hold N_PORTS, port index constants (C=0, N=1, E=2, S=3, W=4) and the allocator state enum {IDLE, LOCKED}.
REQ-028 SHALL instantiate sub-module mesh_rr_arbiter once per output: request vector, pointer and enable in; one-hot grant out; pointer register inside.

Verification
REQ-029 After reset, inputs 1 and 3 request output e (single-flit, i_tail=1) every cycle with i_en=1 -> grants alternate 1,3,1,3; first grant is to 1.
REQ-030 Lock build: input 0 sends a 4-flit packet to output s, tail on flit 4, while input 4 requests s throughout -> 0 is granted 4 consecutive cycles, then 4 on cycle 5.
REQ-031 Hold at i_en=0 for 2 cycles mid-packet -> no grants in those cycles; lock and owner unchanged; resumes with owner.
REQ-032 Bubble: owner deasserts request for 1 cycle while LOCKED and another input requests -> no grant that cycle; lock kept.
REQ-033 Assert reset during LOCKED -> grants zero that cycle; next cycle a new requester 2 is granted immediately; pointer is 0.
REQ-034 Without SWITCH_ALLOC_LOCK_EN: two 3-flit packets from inputs 1 and 2 to output n -> flits interleave 1,2,1,2,1,2.

Source files
------------

// File: rtl/mesh_switch_allocator_pkg.sv
// Shared constants and types for the mesh router switch allocator.
// Port order is c, n, e, s, w; index 0 (c) has top priority after reset.
package MESH_pkg;

  localparam int N_PORTS = 5;

  localparam int C = 0;
  localparam int N = 1;
  localparam int E = 2;
  localparam int S = 3;
  localparam int W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/mesh_switch_allocator_if.sv
// Request/grant bundle between the router input queues, the allocator and the crossbar.
// Row i of i_output_req belongs to input i; row o of o_output_grant belongs to output o.
interface mesh_switch_allocator_if #(
  parameter int N_PORTS = 5
);

  logic [0:N_PORTS-1][0:N_PORTS-1] i_output_req;
  logic [0:N_PORTS-1]              i_tail;
  logic [0:N_PORTS-1]              i_en;
  logic [0:N_PORTS-1][0:N_PORTS-1] o_output_grant;
  logic [0:N_PORTS-1]              o_input_grant;

  modport slave (
    input  i_output_req,
    input  i_tail,
    input  i_en,
    output o_output_grant,
    output o_input_grant
  );

  modport master (
    output i_output_req,
    output i_tail,
    output i_en,
    input  o_output_grant,
    input  o_input_grant
  );

endinterface

// File: rtl/mesh_rr_arbiter.sv
// Round-robin arbiter for one output: picks the first requester at or after the pointer.
// The pointer moves to (upd_idx + 1) mod N_PORTS whenever upd is pulsed.
module mesh_rr_arbiter #(
  parameter  int N_PORTS = 5,
  localparam int PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [0:N_PORTS-1] req,
  input  logic               en,
  input  logic               upd,
  input  logic [PW-1:0]      upd_idx,
  output logic [0:N_PORTS-1] gnt
);

  logic [PW-1:0] ptr_q;
  logic          found;
  int            j;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (upd) begin
      ptr_q <= (upd_idx == PW'(N_PORTS - 1)) ? '0 : upd_idx + 1'b1;
    end
  end

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    if (en) begin
      for (int k = 0; k < N_PORTS; k++) begin
        j = int'(ptr_q) + k;
        if (j >= N_PORTS) j = j - N_PORTS;
        if (!found && req[j]) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mesh_switch_allocator.sv
// Separable switch allocator: one round-robin arbiter per output, grants in the request cycle.
// Define SWITCH_ALLOC_LOCK_EN to hold an output for a whole wormhole packet (head to tail).
//
// state  | meaning
// IDLE   | output free; round-robin arbitration among requesting inputs
// LOCKED | output owned by owner_q until its tail flit is transferred
module mesh_switch_allocator
#(
  parameter int N_PORTS = MESH_pkg::N_PORTS
) (
  input logic                   clk,
  input logic                   reset,
  mesh_switch_allocator_if.slave sw
);

  import MESH_pkg::*;

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [0:N_PORTS-1][0:N_PORTS-1] og;
  logic [0:N_PORTS-1]              ig;

`ifndef SWITCH_ALLOC_LOCK_EN
  // Per-flit arbitration never looks at packet boundaries.
  logic unused_tail;
  assign unused_tail = ^sw.i_tail;
`endif

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [0:N_PORTS-1] req_col;
    logic [0:N_PORTS-1] arb_gnt;
    logic [0:N_PORTS-1] gnt;
    logic               arb_en;
    logic               upd;
    logic               xfer;
    logic [PW-1:0]      win_idx;

    always_comb begin
      req_col = '0;
      for (int i = 0; i < N_PORTS; i++) req_col[i] = sw.i_output_req[i][o];
    end

    always_comb begin
      win_idx = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        if (gnt[i]) win_idx = PW'(i);
      end
    end

    assign xfer = |gnt;

    mesh_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req_col),
      .en      (arb_en),
      .upd     (upd),
      .upd_idx (win_idx),
      .gnt     (arb_gnt)
    );

`ifdef SWITCH_ALLOC_LOCK_EN
    alloc_state_e  state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic          win_tail;

    assign win_tail = |(gnt & sw.i_tail);
    assign arb_en   = sw.i_en[o] && (state_q == IDLE);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        owner_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
      end
    end

    // A locked output ignores everyone but the owner; an owner bubble simply yields no grant.
    always_comb begin
      gnt = '0;
      if (state_q == IDLE) begin
        gnt = arb_gnt;
      end else if (sw.i_en[o] && req_col[owner_q]) begin
        gnt[owner_q] = 1'b1;
      end
    end

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      upd     = 1'b0;
      if (xfer) begin
        if (win_tail) begin
          state_d = IDLE;
          upd     = 1'b1;
        end else if (state_q == IDLE) begin
          state_d = LOCKED;
          owner_d = win_idx;
        end
      end
    end
`else
    assign arb_en = sw.i_en[o];
    assign gnt    = arb_gnt;
    assign upd    = xfer;
`endif

    assign og[o] = reset ? '0 : gnt;
  end

  always_comb begin
    ig = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      for (int i = 0; i < N_PORTS; i++) ig[i] = ig[i] | og[o][i];
    end
  end

  assign sw.o_output_grant = og;
  assign sw.o_input_grant  = ig;

endmodule

// File: tb/tb_mesh_switch_allocator.sv
// Directed bench for mesh_switch_allocator; expectations are hand-derived per scenario.
// Lock scenarios run when SWITCH_ALLOC_LOCK_EN is defined, per-flit scenarios otherwise.
module tb_mesh_switch_allocator;
  import MESH_pkg::*;

  localparam int NP = 5;

  typedef logic [0:NP-1][0:NP-1] mat_t;
  typedef logic [0:NP-1]         vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mesh_switch_allocator_if #(.N_PORTS(NP)) sw ();

  mesh_switch_allocator #(.N_PORTS(NP)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      assert ($onehot0(sw.i_output_req[i]))
        else $error("illegal multi-hot request row at input %0d: %b", i, sw.i_output_req[i]);
    end
  end

  function automatic mat_t one(input int out, input int in);
    mat_t m;
    m = '0;
    if (in >= 0) m[out][in] = 1'b1;
    return m;
  endfunction

  function automatic vec_t bit1(input int i);
    vec_t v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic mat_t rq2(input int ia, input int oa, input int ib, input int ob);
    mat_t m;
    m = '0;
    if (ia >= 0) m[ia][oa] = 1'b1;
    if (ib >= 0) m[ib][ob] = 1'b1;
    return m;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    sw.i_output_req = '0;
    sw.i_tail = '0;
    sw.i_en = '1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    mat_t m;
    reset = 1'b1;
    m = '0;
    for (int i = 0; i < NP; i++) m[i][(i + 1) % NP] = 1'b1;
    sw.i_output_req = m;
    sw.i_tail = '1;
    sw.i_en = '1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== '0) begin
        failures++;
        $display("FAIL reset_og cyc%0d: got %h want 0", k, sw.o_output_grant);
      end
      checks++;
      if (sw.o_input_grant !== '0) begin
        failures++;
        $display("FAIL reset_ig cyc%0d: got %b want 0", k, sw.o_input_grant);
      end
      step();
    end
    reset = 1'b0;
    sw.i_output_req = rq2(4, C, 0, C);
    @(negedge clk);
    checks++;
    if (sw.o_output_grant !== one(C, 0) || sw.o_input_grant !== bit1(0)) begin
      failures++;
      $display("FAIL reset_ptr0: og=%h ig=%b want og=%h ig=%b",
               sw.o_output_grant, sw.o_input_grant, one(C, 0), bit1(0));
    end
    step();
  endtask

  task automatic test_rr;
    int exp_in[4] = '{1, 3, 1, 3};
    do_reset();
    sw.i_output_req = rq2(1, E, 3, E);
    sw.i_tail = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(E, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL rr_alternate cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(E, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
  endtask

  task automatic test_enable;
    logic en_e[5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   exp_in[5] = '{-1, 1, -1, -1, 3};
    do_reset();
    sw.i_output_req = rq2(1, E, 3, E);
    sw.i_tail = '1;
    for (int k = 0; k < 5; k++) begin
      sw.i_en = '1;
      sw.i_en[E] = en_e[k];
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(E, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL enable_hold cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(E, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
    sw.i_en = '1;
  endtask

  task automatic test_multi_output;
    mat_t req, exp_og;
    vec_t exp_ig;
    do_reset();
    req = '0;
    req[0][N] = 1'b1;
    req[1][E] = 1'b1;
    req[2][E] = 1'b1;
    req[3][W] = 1'b1;
    sw.i_output_req = req;
    sw.i_tail = '1;
    for (int k = 0; k < 2; k++) begin
      exp_og = '0;
      exp_og[N][0] = 1'b1;
      exp_og[W][3] = 1'b1;
      exp_og[E][(k == 0) ? 1 : 2] = 1'b1;
      exp_ig = (k == 0) ? 5'b11010 : 5'b10110;
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== exp_og || sw.o_input_grant !== exp_ig) begin
        failures++;
        $display("FAIL multi_output cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, exp_og, exp_ig);
      end
      step();
    end
  endtask

`ifdef SWITCH_ALLOC_LOCK_EN
  task automatic test_lock_build;
    int exp_in[5] = '{0, 0, 0, 0, 4};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sw.i_output_req = rq2((k < 4) ? 0 : -1, S, 4, S);
      sw.i_tail = '0;
      sw.i_tail[0] = (k == 3);
      sw.i_tail[4] = 1'b1;
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(S, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL lock_build cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(S, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
  endtask

  task automatic test_lock_hold;
    logic en_s[6]   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   exp_in[6] = '{0, 0, -1, -1, 0, 4};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sw.i_output_req = rq2((k < 5) ? 0 : -1, S, 4, S);
      sw.i_tail = '0;
      sw.i_tail[0] = (k == 4);
      sw.i_tail[4] = 1'b1;
      sw.i_en = '1;
      sw.i_en[S] = en_s[k];
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(S, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL lock_hold cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(S, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
    sw.i_en = '1;
  endtask

  task automatic test_bubble;
    logic req0[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic tail0[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    int   exp_in[4] = '{0, -1, 0, 4};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      sw.i_output_req = rq2(req0[k] ? 0 : -1, S, 4, S);
      sw.i_tail = '0;
      sw.i_tail[0] = tail0[k];
      sw.i_tail[4] = 1'b1;
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(S, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL bubble cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(S, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
  endtask

  task automatic test_reset_locked;
    int exp_in[4] = '{3, 4, -1, 2};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      reset = (k == 2);
      sw.i_tail = '1;
      sw.i_tail[4] = 1'b0;
      case (k)
        0:       sw.i_output_req = rq2(3, S, -1, S);
        1:       sw.i_output_req = rq2(4, S, -1, S);
        default: sw.i_output_req = rq2(2, S, 4, S);
      endcase
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(S, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL reset_locked cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(S, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
    reset = 1'b0;
  endtask
`else
  task automatic test_interleave;
    int exp_in[7] = '{1, 2, 1, 2, 1, 2, -1};
    int rem1, rem2;
    do_reset();
    rem1 = 3;
    rem2 = 3;
    for (int k = 0; k < 7; k++) begin
      sw.i_output_req = rq2((rem1 > 0) ? 1 : -1, N, (rem2 > 0) ? 2 : -1, N);
      sw.i_tail = '0;
      sw.i_tail[1] = (rem1 == 1);
      sw.i_tail[2] = (rem2 == 1);
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(N, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL interleave cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(N, exp_in[k]), bit1(exp_in[k]));
      end
      if (exp_in[k] == 1) rem1--;
      if (exp_in[k] == 2) rem2--;
      step();
    end
  endtask

  task automatic test_tail_ignored;
    int exp_in[4] = '{0, 4, 0, 4};
    do_reset();
    sw.i_output_req = rq2(0, S, 4, S);
    sw.i_tail = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (sw.o_output_grant !== one(S, exp_in[k]) || sw.o_input_grant !== bit1(exp_in[k])) begin
        failures++;
        $display("FAIL tail_ignored cyc%0d: og=%h ig=%b want og=%h ig=%b", k,
                 sw.o_output_grant, sw.o_input_grant, one(S, exp_in[k]), bit1(exp_in[k]));
      end
      step();
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    sw.i_output_req = '0;
    sw.i_tail = '0;
    sw.i_en = '1;
    #1;
    test_reset();
    test_rr();
    test_enable();
    test_multi_output();
`ifdef SWITCH_ALLOC_LOCK_EN
    test_lock_build();
    test_lock_hold();
    test_bubble();
    test_reset_locked();
`else
    test_interleave();
    test_tail_ignored();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
